// File: rtl/stage_mem_lsu.sv
`timescale 1ns/1ps
// Memory pipeline stage: resolves jumps/branches, issues loads/stores, formats load data.
// Non-memory ops complete in the presenting cycle; memory ops wait on req/resp; wb_stall holds the stage and wb_* regs.
module stage_mem_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic [XLEN-1:0]     mem_pc,
    input  logic [XLEN-1:0]     mem_data0,
    input  logic [XLEN-1:0]     mem_data1,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_extend,
    input  logic [1:0]          mem_width,
    input  logic                mem_jmp,
    input  logic                mem_br,
    input  logic                mem_br_inv,
    input  logic [4:0]          wb_reg,
    input  logic                wb_stall,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    output logic                req_write,
    output logic [XLEN-1:0]     req_wdata,
    output logic [XLEN/8-1:0]   req_be,
    input  logic                resp_valid,
    input  logic [XLEN-1:0]     resp_rdata,
    input  logic                resp_err,
    output logic                mem_wen,
    output logic                fe_enable,
    output logic                pc_wen,
    output logic [XLEN-1:0]     pc,
    output logic                mem_stall,
    output logic                wb_valid,
    output logic [XLEN-1:0]     wb_pc,
    output logic [4:0]          wb_reg_r,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_exc,
    output logic [1:0]          wb_cause
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int XW   = $clog2(XLEN);
    localparam int CW   = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic [XLEN-1:0]   buf_data;
    logic [1:0]        buf_cause;

    logic              is_mem, misaligned, aligned_mem, timeout, complete;
    logic [OFFW-1:0]   off;
    logic [3:0]        size_b;
    logic [6:0]        size_bits;
    logic [NB-1:0]     be_base;
    logic [ADDR_W-1:0] addr_full;
    logic [XLEN-1:0]   shifted, lane_mask, ld_data, cmp_data;
    logic [XW-1:0]     sign_idx;
    logic [1:0]        cmp_cause;

    assign off         = mem_data0[OFFW-1:0];
    assign size_b      = 4'd1 << mem_width;
    assign size_bits   = 7'd8 << mem_width;
    assign is_mem      = mem_read | mem_write;
    assign misaligned  = ((XLEN == 32) && (mem_width == 2'd3)) ||
                         ((off & OFFW'(size_b - 4'd1)) != '0);
    assign aligned_mem = is_mem & ~misaligned;

    assign addr_full = mem_data0[ADDR_W-1:0];
    assign req_addr  = {addr_full[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign req_write = mem_write;
    assign be_base   = ~({NB{1'b1}} << size_b);
    assign req_be    = be_base << off;

    always_comb begin
        case (mem_width)
            2'd0:    req_wdata = {NB{mem_data1[7:0]}};
            2'd1:    req_wdata = {(NB/2){mem_data1[15:0]}};
            2'd2:    req_wdata = {(NB/4){mem_data1[31:0]}};
            default: req_wdata = mem_data1;
        endcase
    end

    // Right-justify the addressed lane, then fill the upper bits with zero or the lane's sign.
    assign shifted   = resp_rdata >> {off, 3'b000};
    assign lane_mask = ~({XLEN{1'b1}} << size_bits);
    assign sign_idx  = XW'(size_bits - 7'd1);
    assign ld_data   = (shifted & lane_mask) |
                       ((mem_extend & shifted[sign_idx]) ? ~lane_mask : '0);

    assign req_valid = ((state == IDLE) & mem_valid & aligned_mem) | (state == REQ);
    assign timeout   = (TIMEOUT != 0) && (state == REQ) && !req_ready &&
                       (wait_cnt >= CW'(TIMEOUT - 1));

    always_comb begin
        complete  = 1'b0;
        cmp_cause = 2'd0;
        cmp_data  = mem_data0;
        case (state)
            IDLE: begin
                if (!aligned_mem) begin
                    complete = mem_valid & ~wb_stall;
                    if (is_mem) begin
                        cmp_cause = 2'd1;
                        cmp_data  = '0;
                    end
                end
            end
            REQ: begin
                if (timeout) begin
                    complete  = ~wb_stall;
                    cmp_cause = 2'd3;
                    cmp_data  = '0;
                end
            end
            RESP: begin
                if (resp_valid) begin
                    complete  = ~wb_stall;
                    cmp_cause = resp_err ? 2'd2 : 2'd0;
                    cmp_data  = resp_err ? '0 : (mem_read ? ld_data : mem_data0);
                end
            end
            default: begin
                complete  = ~wb_stall;
                cmp_cause = buf_cause;
                cmp_data  = buf_data;
            end
        endcase
    end

    assign mem_stall = mem_valid & ~complete;
    assign fe_enable = complete & (mem_jmp | mem_br);
    assign pc_wen    = complete & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
    assign pc        = mem_data1;
    assign mem_wen   = mem_valid & ~is_mem & (wb_reg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            buf_data  <= '0;
            buf_cause <= 2'd0;
            wb_valid  <= 1'b0;
            wb_pc     <= '0;
            wb_reg_r  <= 5'd0;
            wb_data   <= '0;
            wb_exc    <= 1'b0;
            wb_cause  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid & aligned_mem) begin
                        state    <= req_ready ? RESP : REQ;
                        wait_cnt <= (TIMEOUT != 0 && !req_ready) ? CW'(1) : '0;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        wait_cnt <= '0;
                        if (wb_stall) begin
                            state     <= HOLD;
                            buf_cause <= 2'd3;
                            buf_data  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_valid) begin
                        if (wb_stall) begin
                            state     <= HOLD;
                            buf_cause <= cmp_cause;
                            buf_data  <= cmp_data;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    if (!wb_stall) state <= IDLE;
                end
            endcase

            if (!wb_stall) begin
                wb_valid <= complete;
                if (complete) begin
                    wb_pc    <= mem_pc;
                    wb_reg_r <= (cmp_cause != 2'd0) ? 5'd0 : wb_reg;
                    wb_data  <= cmp_data;
                    wb_exc   <= (cmp_cause != 2'd0);
                    wb_cause <= cmp_cause;
                end
            end
        end
    end
endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
- Parametrised successor to the pipeline memory stage; sits between execute and writeback.
- Resolves jumps and branches and issues loads and stores over a valid/ready request channel plus a separate response channel.
- Performs byte-lane steering, store byte enables and load sign/zero extension internally.
- Detects misaligned accesses, bus errors and request timeouts, and reports them to writeback as exceptions.

Parameters:
XLEN, 32, datapath width; 32 or 64.
ADDR_W, 32, memory address width.
TIMEOUT, 16, max cycles req_valid may wait for req_ready; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
mem_valid  in  1  execute-stage instruction valid
mem_pc  in  XLEN  instruction PC
mem_data0  in  XLEN  address, ALU result or branch condition (bit0)
mem_data1  in  XLEN  store data or jump/branch target
mem_read / mem_write  in  1  load / store
mem_extend  in  1  1 = sign-extend load
mem_width  in  2  0=byte, 1=half, 2=word, 3=double (XLEN=64 only)
mem_jmp / mem_br / mem_br_inv  in  1  jump, branch, invert condition
wb_reg  in  5  destination register
wb_stall  in  1  writeback cannot accept
req_valid  out  1  memory request
req_ready  in  1  memory accepts request
req_addr  out  ADDR_W  address with low log2(XLEN/8) bits zeroed
req_write  out  1  store
req_wdata  out  XLEN  lane-replicated store data
req_be  out  XLEN/8  byte enables
resp_valid  in  1  response (exactly one per accepted request)
resp_rdata  in  XLEN  load data
resp_err  in  1  bus error on response
mem_wen  out  1  forwarding: non-memory op writes a nonzero register
fe_enable / pc_wen  out  1  redirect fetch / write PC
pc  out  XLEN  = mem_data1
mem_stall  out  1  hold execute
wb_valid  out  1  writeback valid
wb_pc  out  XLEN  PC of the instruction in writeback
wb_reg_r  out  5  destination register of the instruction in writeback
wb_data  out  XLEN  ALU result or formatted load data
wb_exc  out  1  exception flag
wb_cause  out  2  0 = none, 1 = misaligned/illegal width, 2 = bus error, 3 = timeout

Behaviour:
- Reset (async, immediate): state=IDLE; all wb_* outputs = 0; wait counter = 0.
- Upstream holds all mem_* inputs stable while mem_stall=1.
- off = mem_data0[log2(XLEN/8)-1:0].
- Misaligned when off is not a multiple of the access size (1 << mem_width bytes).
- mem_width=3 with XLEN=32 is illegal and is treated as misaligned.
- Store data: byte is replicated to every lane, half to every half, word to every word.
- req_be = ((1 << size) - 1) << off.
- Load data: resp_rdata >> (off*8), truncated to the access size, then sign- or zero-extended per mem_extend.

FSM:
- IDLE, no memory op, or misaligned access:
  - complete = mem_valid & ~wb_stall.
  - A misaligned access never asserts req_valid.
- IDLE, aligned memory op:
  - req_valid = mem_valid, combinational.
  - req_ready=1 goes to RESP; otherwise goes to REQ.
- REQ:
  - req_valid stays 1 with stable outputs.
  - req_ready goes to RESP.
  - Counter increments each cycle. When it reaches TIMEOUT-1 without req_ready, drop req_valid, return to IDLE and complete with cause 3 (held until ~wb_stall).
- RESP:
  - On resp_valid with ~wb_stall: complete, go to IDLE.
  - On resp_valid with wb_stall: latch formatted data and err into a buffer, go to HOLD.
  - A response in the same cycle as request acceptance is not permitted (response latency >= 1).
- HOLD: on ~wb_stall, complete from the buffer and go to IDLE.

Handshake and outputs:
- mem_stall = mem_valid & ~complete.
- On complete, next edge: wb_valid=1; wb_pc, wb_reg_r and wb_data load; wb_exc and wb_cause set.
- resp_err=1 gives cause 2, and wb_data=0.
- Exceptions force wb_reg_r=0 so no register is written.
- If wb_stall=1: all wb_* registers hold.
- Otherwise, when not completing: wb_valid=0.
- fe_enable = complete & (mem_jmp | mem_br).
- pc_wen = complete & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv))).
- Each redirect therefore pulses exactly once.
- mem_wen = mem_valid & ~(mem_read|mem_write) & (wb_reg != 0).

Test Plan:
- lbu at addr 0x1003, resp_rdata=0x80AA55CC, no stall -> req_be=4'b1000, req_addr=0x1000, wb_data=0x00000080; lb on same access -> 0xFFFFFF80.
- sh at addr 0x2002, data1=0x1234ABCD -> req_be=4'b1100, req_wdata=0xABCDABCD, req_write=1, wb_valid=1 one cycle after the response.
- lw at 0x3001 -> no req_valid; wb_exc=1, wb_cause=1, wb_reg_r=0, mem_stall=0 in the same cycle.
- req_ready=0 for 16 cycles, TIMEOUT=16 -> req_valid drops after 16 cycles, wb_cause=3; a later resp_valid is never observed.
- resp_valid arrives while wb_stall=1 for 3 cycles -> HOLD; wb_* hold the prior values; mem_stall=1; data is delivered the cycle after wb_stall falls.
- beq taken (data0[0]=1, br_inv=0, data1=0x400) during wb_stall=1 for 2 cycles -> pc_wen=1, pc=0x400 exactly once, on the first unstalled cycle; assert reset mid-RESP -> IDLE, wb_valid=0 immediately.
